// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative restoring divider, signed/unsigned, start/ready handshake with annul
// Define DIV_EARLY_EXIT_EN to skip iterations when |dividend| < |divisor|.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_zero_o
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DIVBYZERO, ON, END} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dsr;
   logic             neg_q, neg_r, dz;

   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff;
   logic             take, early, last_step;
   logic [WIDTH-1:0] q_fix, r_fix;

   always_comb begin
      mag1      = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      mag2      = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
      // Trial value needs one extra bit: the shifted remainder can exceed WIDTH bits.
      trial     = {rem, quo[WIDTH-1]};
      take      = (trial >= {1'b0, dsr});
      diff      = trial[WIDTH-1:0] - dsr;
      last_step = (cnt == CW'(WIDTH - 1));
      q_fix     = neg_q ? -quo : quo;
      r_fix     = neg_r ? -rem : rem;
`ifdef DIV_EARLY_EXIT_EN
      early     = (mag1 < mag2);
`else
      early     = 1'b0;
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) state_next = DIVBYZERO;
               else if (early)      state_next = END;
               else                 state_next = ON;
            end
         end
         DIVBYZERO: state_next = annul_i ? IDLE : END;
         ON: begin
            if (annul_i)        state_next = IDLE;
            else if (last_step) state_next = END;
         end
         END: begin
            if (!start_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         rem        <= '0;
         quo        <= '0;
         dsr        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         dz         <= 1'b0;
         result_o   <= '0;
         ready_o    <= 1'b0;
         busy_o     <= 1'b0;
         div_zero_o <= 1'b0;
      end else begin
         busy_o <= (state == ON) || (state == DIVBYZERO);
         case (state)
            IDLE: begin
               ready_o    <= 1'b0;
               result_o   <= '0;
               div_zero_o <= 1'b0;
               if (start_i && !annul_i) begin
                  dsr   <= mag2;
                  neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                  dz    <= (opdata2_i == '0);
                  cnt   <= '0;
                  // Early exit parks the dividend magnitude as the final remainder.
                  if (early) begin
                     quo <= '0;
                     rem <= mag1;
                  end else begin
                     quo <= mag1;
                     rem <= '0;
                  end
               end
            end
            DIVBYZERO: begin
               quo   <= '0;
               rem   <= '0;
               neg_q <= 1'b0;
               neg_r <= 1'b0;
            end
            ON: begin
               rem <= take ? diff : trial[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], take};
               cnt <= cnt + CW'(1);
            end
            END: begin
               if (start_i) begin
                  ready_o    <= 1'b1;
                  result_o   <= {r_fix, q_fix};
                  div_zero_o <= dz;
               end else begin
                  ready_o    <= 1'b0;
                  result_o   <= '0;
                  div_zero_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed self-checking bench for div_iter (WIDTH=32 and WIDTH=8 instances)
module tb_div_iter;
`ifdef DIV_EARLY_EXIT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 9;
`endif

   logic        clk, rst;
   logic        sd, start, annul;
   logic [31:0] op1, op2;
   logic [63:0] result32;
   logic        ready32, busy32, dz32;
   logic        sd8, start8, annul8;
   logic [7:0]  a8, b8;
   logic [15:0] result8;
   logic        ready8, busy8, dz8;

   int errors = 0;
   int checks = 0;

   div_iter #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .signed_div_i(sd), .opdata1_i(op1), .opdata2_i(op2),
      .start_i(start), .annul_i(annul), .result_o(result32), .ready_o(ready32),
      .busy_o(busy32), .div_zero_o(dz32)
   );

   div_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .signed_div_i(sd8), .opdata1_i(a8), .opdata2_i(b8),
      .start_i(start8), .annul_i(annul8), .result_o(result8), .ready_o(ready8),
      .busy_o(busy8), .div_zero_o(dz8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b, input int lim,
                        output int lat, output logic [63:0] res, output logic dz);
      lat = -1; res = '0; dz = 1'b0;
      @(negedge clk);
      sd = s; op1 = a; op2 = b; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= lim; k++) begin
         @(posedge clk); #1;
         if (ready32) begin
            lat = k; res = result32; dz = dz32;
            break;
         end
      end
   endtask

   task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, input int lim,
                       output int lat, output logic [15:0] res);
      lat = -1; res = '0;
      @(negedge clk);
      sd8 = s; a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= lim; k++) begin
         @(posedge clk); #1;
         if (ready8) begin
            lat = k; res = result8;
            break;
         end
      end
   endtask

   task automatic release32();
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic release8();
      @(negedge clk); start8 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; sd = 0; op1 = 0; op2 = 0; start = 0; annul = 0;
      sd8 = 0; a8 = 0; b8 = 0; start8 = 0; annul8 = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({ready32, busy32, dz32} !== 3'b000 || result32 !== 64'd0) begin
         errors++; $display("FAIL reset32: got rdy/busy/dz=%b res=%h expected 000 res=0", {ready32, busy32, dz32}, result32);
      end
      checks++;
      if ({ready8, busy8, dz8} !== 3'b000 || result8 !== 16'd0) begin
         errors++; $display("FAIL reset8: got rdy/busy/dz=%b res=%h expected 000 res=0", {ready8, busy8, dz8}, result8);
      end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy32 !== 1'b0 || ready32 !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: got busy=%b ready=%b expected 0 0", busy32, ready32);
      end
   endtask

   task automatic test_unsigned();
      logic [63:0] held;
      held = '0;
      @(negedge clk);
      sd = 0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk); #1;
         if (k == 1 || k == 32) begin
            checks++;
            if (busy32 !== 1'b1 || ready32 !== 1'b0 || result32 !== 64'd0) begin
               errors++; $display("FAIL busy_edge%0d: got busy=%b ready=%b res=%h expected 1 0 0", k, busy32, ready32, result32);
            end
         end
         if (k == 33) begin
            checks++;
            if (ready32 !== 1'b1 || busy32 !== 1'b0) begin
               errors++; $display("FAIL ready_edge33: got ready=%b busy=%b expected 1 0", ready32, busy32);
            end
            checks++;
            if (result32 !== {32'd2, 32'd14} || dz32 !== 1'b0) begin
               errors++; $display("FAIL u100_7: got %h dz=%b expected %h dz=0", result32, dz32, {32'd2, 32'd14});
            end
            held = result32;
         end
      end
      op1 = 32'd55; op2 = 32'd5;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready32 !== 1'b1 || result32 !== {32'd2, 32'd14}) begin
         errors++; $display("FAIL hold: got ready=%b res=%h expected 1 %h (was %h)", ready32, result32, {32'd2, 32'd14}, held);
      end
      release32();
      checks++;
      if ({ready32, busy32, dz32} !== 3'b000 || result32 !== 64'd0) begin
         errors++; $display("FAIL drop_start: got rdy/busy/dz=%b res=%h expected 000 0", {ready32, busy32, dz32}, result32);
      end
   endtask

   task automatic test_signed();
      int lat; logic [63:0] res; logic dz;
      run32(1'b1, 32'hFFFFFFF9, 32'd2, 40, lat, res, dz);
      checks++;
      if (res !== 64'hFFFFFFFF_FFFFFFFD || lat !== 33) begin
         errors++; $display("FAIL s_m7_2: got %h lat=%0d expected FFFFFFFFFFFFFFFD lat=33", res, lat);
      end
      release32();
      run32(1'b1, 32'h80000000, 32'hFFFFFFFF, 40, lat, res, dz);
      checks++;
      if (res !== 64'h00000000_80000000 || dz !== 1'b0) begin
         errors++; $display("FAIL s_overflow: got %h dz=%b expected 0000000080000000 dz=0", res, dz);
      end
      release32();
      run32(1'b1, 32'd7, 32'hFFFFFFFE, 40, lat, res, dz);
      checks++;
      if (res !== 64'h00000001_FFFFFFFD) begin
         errors++; $display("FAIL s_7_m2: got %h expected 00000001FFFFFFFD", res);
      end
      release32();
      run32(1'b0, 32'h80000000, 32'hFFFFFFFF, 40, lat, res, dz);
      checks++;
      if (res !== 64'h80000000_00000000) begin
         errors++; $display("FAIL u_big_small: got %h expected 8000000000000000", res);
      end
      release32();
      run32(1'b0, 32'hFFFFFFFF, 32'd1, 40, lat, res, dz);
      checks++;
      if (res !== 64'h00000000_FFFFFFFF) begin
         errors++; $display("FAIL u_max_1: got %h expected 00000000FFFFFFFF", res);
      end
      release32();
   endtask

   task automatic test_div_zero();
      int lat; logic [63:0] res; logic dz;
      run32(1'b0, 32'd5, 32'd0, 40, lat, res, dz);
      checks++;
      if (lat !== 2 || res !== 64'd0 || dz !== 1'b1) begin
         errors++; $display("FAIL div_zero: got lat=%0d res=%h dz=%b expected 2 0 1", lat, res, dz);
      end
      release32();
      checks++;
      if ({ready32, busy32, dz32} !== 3'b000 || result32 !== 64'd0) begin
         errors++; $display("FAIL div_zero_clear: got rdy/busy/dz=%b res=%h expected 000 0", {ready32, busy32, dz32}, result32);
      end
   endtask

   task automatic test_annul();
      int seen; int lat; logic [63:0] res; logic dz;
      seen = 0;
      @(negedge clk);
      sd = 0; op1 = 32'h12345678; op2 = 32'h11; start = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (busy32 !== 1'b1) begin
         errors++; $display("FAIL annul_pre_busy: got %b expected 1", busy32);
      end
      @(negedge clk); annul = 1'b1; start = 1'b0;
      @(posedge clk);
      @(negedge clk); annul = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (ready32 !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0 || busy32 !== 1'b0) begin
         errors++; $display("FAIL annul: got ready_cycles=%0d busy=%b expected 0 0", seen, busy32);
      end
      run32(1'b0, 32'd9, 32'd3, 40, lat, res, dz);
      checks++;
      if (res !== 64'h00000000_00000003 || lat !== 33) begin
         errors++; $display("FAIL after_annul_9_3: got %h lat=%0d expected 0000000000000003 lat=33", res, lat);
      end
      release32();
   endtask

   task automatic test_width8();
      int lat; logic [15:0] res;
      run8(1'b0, 8'd200, 8'd9, 20, lat, res);
      checks++;
      if (res !== 16'h0216 || lat !== 9) begin
         errors++; $display("FAIL w8_200_9: got %h lat=%0d expected 0216 lat=9", res, lat);
      end
      release8();
      run8(1'b0, 8'd3, 8'd9, 20, lat, res);
      checks++;
      if (res !== 16'h0300 || lat !== EARLY_LAT) begin
         errors++; $display("FAIL w8_3_9: got %h lat=%0d expected 0300 lat=%0d", res, lat, EARLY_LAT);
      end
      release8();
      run8(1'b1, 8'h9C, 8'd7, 20, lat, res);
      checks++;
      if (res !== 16'hFEF2) begin
         errors++; $display("FAIL w8_m100_7: got %h expected FEF2", res);
      end
      release8();
      run8(1'b1, 8'h80, 8'hFF, 20, lat, res);
      checks++;
      if (res !== 16'h0080 || lat !== 9) begin
         errors++; $display("FAIL w8_overflow: got %h lat=%0d expected 0080 lat=9", res, lat);
      end
      release8();
      run8(1'b0, 8'hFF, 8'hFF, 20, lat, res);
      checks++;
      if (res !== 16'h0001) begin
         errors++; $display("FAIL w8_255_255: got %h expected 0001", res);
      end
      release8();
   endtask

   task automatic test_async_reset();
      int lat; logic [63:0] res; logic dz; int seen;
      seen = 0;
      @(negedge clk);
      sd = 0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      @(posedge clk);
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (busy32 !== 1'b1) begin
         errors++; $display("FAIL pre_rst_busy: got %b expected 1", busy32);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ready32, busy32, dz32} !== 3'b000 || result32 !== 64'd0) begin
         errors++; $display("FAIL async_rst: got rdy/busy/dz=%b res=%h expected 000 0", {ready32, busy32, dz32}, result32);
      end
      @(negedge clk); start = 1'b0; rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (busy32 !== 1'b0 || ready32 !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL rst_no_restart: got active_cycles=%0d expected 0", seen);
      end
      run32(1'b0, 32'd20, 32'd6, 40, lat, res, dz);
      checks++;
      if (res !== 64'h00000002_00000003 || lat !== 33) begin
         errors++; $display("FAIL after_rst_20_6: got %h lat=%0d expected 0000000200000003 lat=33", res, lat);
      end
      release32();
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_annul();
      test_width8();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative divider for the execute stage. Computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, one quotient bit per cycle, using a start/ready handshake with annul. ex drives the operands and start signal and stalls the pipeline through stallreq until ready_o is high. The block adds a divide-by-zero flag, a busy indicator and an optional early exit.

## Interface
- WIDTH, 32: operand width in bits; any value ≥ 4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- signed_div_i  in  1  1 = two's-complement division, 0 = unsigned; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- start_i  in  1  request; level-held by ex until result consumed.
- annul_i  in  1  abort the in-flight division (branch/exception flush).
- result_o  out  2*WIDTH  {remainder, quotient}; valid only while ready_o=1, else 0.
- ready_o  out  1  result valid.
- busy_o  out  1  high in DIVBYZERO and ON states.
- div_zero_o  out  1  divisor was zero; valid with ready_o.

## Operation
- States: IDLE, DIVBYZERO, ON, END. Reset → IDLE; all outputs 0, internal counter 0, partial remainder 0.
- IDLE:
  - start_i=1 and annul_i=0: capture operands and signed_div_i.
  - Divisor 0 → DIVBYZERO; otherwise → ON with cnt=0.
  - start_i=0, or annul_i=1 → stay IDLE.
- Signed mode: operands converted to magnitude (two's-complement negate if MSB set) at capture.
- ON:
  - Restoring step per cycle: shift {rem, dividend} left 1, trial-subtract the divisor magnitude, set quotient LSB to 1 if the result is non-negative and keep the difference, else 0.
  - cnt increments; after WIDTH steps → END.
  - annul_i=1 → IDLE at next edge; result discarded, ready_o stays 0.
- DIVBYZERO: → END next edge with result 0 and div_zero_o=1. annul_i=1 → IDLE instead.
- END:
  - Sign fix-up is applied when the result is registered.
  - Quotient is negated if the operand signs differ (signed mode only).
  - Remainder is negated if the dividend was negative (signed mode only).
  - ready_o=1 and result_o is held while start_i=1; annul_i is ignored.
  - start_i=0 → IDLE next edge; ready_o, result_o and div_zero_o are cleared.
- Overflow case (signed, most-negative / −1): quotient = 1 followed by WIDTH−1 zeros, remainder 0; no flag.
- Operand changes while not in IDLE are ignored.
- A new start requires a return to IDLE, i.e. start_i must drop for at least one cycle.

## Timing
- Edge 0 is the edge that samples start_i=1 in IDLE.
- Normal division: ON occupies edges 1..WIDTH; END is entered at edge WIDTH+1. ready_o is high from edge WIDTH+1 (33 edges for WIDTH=32).
- Divide by zero: ready_o is high from edge 2.
- busy_o is a registered state decode; it rises at edge 1 and falls on entry to END.
- Reset asserted at any time clears state and outputs immediately, with no clock required.
- Simultaneous start_i and annul_i in IDLE: annul wins, no capture.

## Configuration
- DIV_EARLY_EXIT_EN defined:
  - In IDLE, a non-zero divisor with |dividend| < |divisor| (magnitudes) goes directly to END at edge 1.
  - Result is quotient 0 and remainder = original signed dividend; ready_o is high from edge 1.
  - Dividend 0 is included in this path.
- DIV_EARLY_EXIT_EN undefined: every non-zero divisor takes the full WIDTH iterations. Results are bit-identical either way; only latency differs.

## Test plan
- Unsigned, WIDTH=32: 100 / 7, start held → ready_o at edge 33, result_o = {32'd2, 32'd14}, div_zero_o=0.
- Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Then 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divisor 0: 5 / 0 → ready_o at edge 2, result_o=0, div_zero_o=1. Drop start_i → all outputs 0 next edge.
- annul_i pulsed at edge 10 of a 32-bit division → IDLE at edge 11, ready_o never rises. A following 9 / 3 completes correctly with quotient 3, remainder 0.
- WIDTH=8 instance, unsigned 200 / 9 → ready_o at edge 9, result_o = {8'd2, 8'd22}. With DIV_EARLY_EXIT_EN, 3 / 9 → ready_o at edge 1, result_o = {8'd3, 8'd0}.
- rst asserted mid-ON at edge 15 → ready_o, busy_o and result_o go to 0 asynchronously. After release, start_i is needed to begin again.
